highscore_bcd_scanner: RTL

- Downstream consumer of the high-score table (five 8-bit scores, hi1 best … hi5 worst).
- Steps through ranks 1..5 in turn, automatically on a dwell timer or manually on a next pulse.
- Converts the selected score to three BCD digits with a sequential double-dabble engine (one iteration per clock).
- Digits, rank and valid drive the HEX / on-screen leaderboard display.

---
 rtl/highscore_bcd_scanner_if.sv | 25 ++
 rtl/highscore_bcd_scanner.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/highscore_bcd_scanner_if.sv
// Leaderboard scanner bus: score table in, selected rank and BCD digits out.
interface highscore_bcd_scanner_if;
    logic       show;
    logic       next;
    logic [7:0] hi1;
    logic [7:0] hi2;
    logic [7:0] hi3;
    logic [7:0] hi4;
    logic [7:0] hi5;
    logic [2:0] rank;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       valid;

    modport master (
        output show, next, hi1, hi2, hi3, hi4, hi5,
        input  rank, hundreds, tens, ones, valid
    );

    modport slave (
        input  show, next, hi1, hi2, hi3, hi4, hi5,
        output rank, hundreds, tens, ones, valid
    );
endinterface

// File: rtl/highscore_bcd_scanner.sv
// Steps through the five high scores and converts each to BCD with a
// one-iteration-per-clock double-dabble engine for the leaderboard display.
module highscore_bcd_scanner #(
    parameter int DWELL_CYCLES = 50000000,
    parameter int CNT_W        = 26
) (
    input logic                    clk,
    input logic                    resetn,
    highscore_bcd_scanner_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DISPLAY
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t           r_state;
    logic [2:0]       r_rank;
    logic [3:0]       r_hund;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic             r_valid;
    logic [CNT_W-1:0] r_dwell;
    logic [2:0]       r_iter;
    logic [7:0]       r_bin;
    logic [11:0]      r_bcd;

    state_t           w_state_nx;
    logic [2:0]       w_rank_nx;
    logic [3:0]       w_hund_nx;
    logic [3:0]       w_tens_nx;
    logic [3:0]       w_ones_nx;
    logic             w_valid_nx;
    logic [CNT_W-1:0] w_dwell_nx;
    logic [2:0]       w_iter_nx;
    logic [7:0]       w_bin_nx;
    logic [11:0]      w_bcd_nx;
    logic [7:0]       w_hi_sel;
    logic [11:0]      w_bcd_adj;
    logic [19:0]      w_shift;

    // Nibbles are adjusted independently; no carry crosses a nibble boundary.
    assign w_bcd_adj[3:0]   = (r_bcd[3:0]   >= 4'd5) ? r_bcd[3:0]   + 4'd3 : r_bcd[3:0];
    assign w_bcd_adj[7:4]   = (r_bcd[7:4]   >= 4'd5) ? r_bcd[7:4]   + 4'd3 : r_bcd[7:4];
    assign w_bcd_adj[11:8]  = (r_bcd[11:8]  >= 4'd5) ? r_bcd[11:8]  + 4'd3 : r_bcd[11:8];
    assign w_shift          = {w_bcd_adj[10:0], r_bin, 1'b0};

    always_comb begin
        w_hi_sel = 8'd0;
        unique case (r_rank)
            3'd1:    w_hi_sel = bus.hi1;
            3'd2:    w_hi_sel = bus.hi2;
            3'd3:    w_hi_sel = bus.hi3;
            3'd4:    w_hi_sel = bus.hi4;
            3'd5:    w_hi_sel = bus.hi5;
            default: w_hi_sel = 8'd0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_rank_nx  = r_rank;
        w_hund_nx  = r_hund;
        w_tens_nx  = r_tens;
        w_ones_nx  = r_ones;
        w_valid_nx = r_valid;
        w_dwell_nx = r_dwell;
        w_iter_nx  = r_iter;
        w_bin_nx   = r_bin;
        w_bcd_nx   = r_bcd;
        unique case (r_state)
            IDLE: begin
                if (bus.show) begin
                    w_state_nx = LOAD;
                    w_rank_nx  = 3'd1;
                end
            end
            LOAD: begin
                w_bin_nx   = w_hi_sel;
                w_bcd_nx   = 12'd0;
                w_iter_nx  = 3'd0;
                w_valid_nx = 1'b0;
                w_state_nx = SHIFT;
            end
            SHIFT: begin
                w_bcd_nx  = w_shift[19:8];
                w_bin_nx  = w_shift[7:0];
                w_iter_nx = r_iter + 3'd1;
                if (r_iter == 3'd7) begin
                    w_hund_nx  = w_shift[19:16];
                    w_tens_nx  = w_shift[15:12];
                    w_ones_nx  = w_shift[11:8];
                    w_valid_nx = 1'b1;
                    w_dwell_nx = '0;
                    w_state_nx = DISPLAY;
                end
            end
            DISPLAY: begin
                w_dwell_nx = r_dwell + 1'b1;
                if (bus.next || r_dwell == DWELL_LAST) begin
                    w_rank_nx  = (r_rank == 3'd5) ? 3'd1 : r_rank + 3'd1;
                    w_valid_nx = 1'b0;
                    w_state_nx = LOAD;
                end
            end
            default: w_state_nx = IDLE;
        endcase
        // Dropping show abandons whatever is in flight.
        if (!bus.show && r_state != IDLE) begin
            w_state_nx = IDLE;
            w_rank_nx  = 3'd0;
            w_hund_nx  = 4'd0;
            w_tens_nx  = 4'd0;
            w_ones_nx  = 4'd0;
            w_valid_nx = 1'b0;
            w_dwell_nx = '0;
            w_iter_nx  = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_rank  <= 3'd0;
            r_hund  <= 4'd0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
            r_valid <= 1'b0;
            r_dwell <= '0;
            r_iter  <= 3'd0;
            r_bin   <= 8'd0;
            r_bcd   <= 12'd0;
        end else begin
            r_state <= w_state_nx;
            r_rank  <= w_rank_nx;
            r_hund  <= w_hund_nx;
            r_tens  <= w_tens_nx;
            r_ones  <= w_ones_nx;
            r_valid <= w_valid_nx;
            r_dwell <= w_dwell_nx;
            r_iter  <= w_iter_nx;
            r_bin   <= w_bin_nx;
            r_bcd   <= w_bcd_nx;
        end
    end

    assign bus.rank     = r_rank;
    assign bus.hundreds = r_hund;
    assign bus.tens     = r_tens;
    assign bus.ones     = r_ones;
    assign bus.valid    = r_valid;
endmodule
